// File: rtl/pipe_phy_cmd_resp.sv
// PIPE PHY command/response model for one lane.
// Sequences powerdown changes, rate changes and receiver detect. Each
// accepted command ends with a one-cycle phystatus completion pulse. After
// reset, phystatus is held high for RST_LAT cycles.
module pipe_phy_cmd_resp #(
  parameter int RST_LAT  = 8,
  parameter int PD_LAT   = 4,
  parameter int RATE_LAT = 8,
  parameter int DET_LAT  = 16
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic [2:0] powerdown,
  input  logic [1:0] rate,
  input  logic       txdetectrx,
  input  logic       txelecidle,
  input  logic       rx_present,
  output logic       phystatus,
  output logic [2:0] rxstatus,
  output logic [2:0] cur_powerdown,
  output logic [1:0] cur_rate,
  output logic       busy,
  output logic       invalid_req
);

  typedef enum logic [2:0] {
    HOLD,
    IDLE,
    PD_WAIT,
    RATE_WAIT,
    DET_WAIT,
    ACK
  } state_t;

  localparam logic [2:0] PD_P1     = 3'd2;
  localparam logic [2:0] RX_DET    = 3'b011;
  // Counter preloads. A wait entered at edge k reaches ACK at edge k+LAT.
  localparam logic [7:0] RST_CNT  = 8'(RST_LAT - 1);
  localparam logic [7:0] PD_CNT   = 8'(PD_LAT - 1);
  localparam logic [7:0] RATE_CNT = 8'(RATE_LAT - 1);
  localparam logic [7:0] DET_CNT  = 8'(DET_LAT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] tgt_pd_q, tgt_pd_d;
  logic [1:0] tgt_rate_q, tgt_rate_d;
  logic [2:0] cur_pd_q, cur_pd_d;
  logic [1:0] cur_rate_q, cur_rate_d;
  logic       det_armed_q, det_armed_d;
  logic       det_hit_q, det_hit_d;
  logic       busy_q, busy_d;
  logic       invalid_q, invalid_d;

  logic pd_valid, rate_valid;

  assign pd_valid   = (powerdown < 3'd4);
  assign rate_valid = (rate != 2'd3);

  // State register and all per-command context.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HOLD;
      cnt_q       <= RST_CNT;
      tgt_pd_q    <= PD_P1;
      tgt_rate_q  <= 2'd0;
      cur_pd_q    <= PD_P1;
      cur_rate_q  <= 2'd0;
      det_armed_q <= 1'b1;
      det_hit_q   <= 1'b0;
      busy_q      <= 1'b1;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_pd_q    <= tgt_pd_d;
      tgt_rate_q  <= tgt_rate_d;
      cur_pd_q    <= cur_pd_d;
      cur_rate_q  <= cur_rate_d;
      det_armed_q <= det_armed_d;
      det_hit_q   <= det_hit_d;
      busy_q      <= busy_d;
      invalid_q   <= invalid_d;
    end
  end

  // Next-state logic: sample commands in IDLE, count down the waits, and
  // commit the new power state or rate on entry to ACK.
  always_comb begin
    // NOTE: every signal assigned here gets a default first. No path can
    // leave one unassigned, so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    tgt_pd_d    = tgt_pd_q;
    tgt_rate_d  = tgt_rate_q;
    cur_pd_d    = cur_pd_q;
    cur_rate_d  = cur_rate_q;
    det_armed_d = det_armed_q;
    det_hit_d   = det_hit_q;
    invalid_d   = 1'b0;

    unique case (state_q)
      HOLD: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end

      IDLE: begin
        // Releasing txdetectrx re-arms detect, so a held request detects once.
        if (!txdetectrx) det_armed_d = 1'b1;

        if (!pd_valid || !rate_valid) begin
          invalid_d = 1'b1;
        end else if (powerdown != cur_pd_q) begin
          state_d  = PD_WAIT;
          cnt_d    = PD_CNT;
          tgt_pd_d = powerdown;
        end else if (rate != cur_rate_q) begin
          state_d    = RATE_WAIT;
          cnt_d      = RATE_CNT;
          tgt_rate_d = rate;
        end else if (txdetectrx && (cur_pd_q == PD_P1) && txelecidle && det_armed_q) begin
          state_d     = DET_WAIT;
          cnt_d       = DET_CNT;
          det_armed_d = 1'b0;
        end
      end

      PD_WAIT, RATE_WAIT, DET_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d   = ACK;
          det_hit_d = (state_q == DET_WAIT) && rx_present;
          if (state_q == PD_WAIT)   cur_pd_d   = tgt_pd_q;
          if (state_q == RATE_WAIT) cur_rate_d = tgt_rate_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ACK: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // busy rises one edge after the sampling edge and falls after ACK.
    busy_d = (state_d != IDLE) && (state_q != IDLE);
  end

  assign phystatus     = (state_q == HOLD) || (state_q == ACK);
  assign rxstatus      = ((state_q == ACK) && det_hit_q) ? RX_DET : 3'b000;
  assign cur_powerdown = cur_pd_q;
  assign cur_rate      = cur_rate_q;
  assign busy          = busy_q;
  assign invalid_req   = invalid_q;

endmodule
